// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the CPU datapath.
// The sequencer drives the master side; the datapath drives op and zero.
interface multi_cycle_ctrl_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         op;
    logic               zero;
    logic               PCWre;
    logic               IRWre;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic               DBDataSrc;
    logic               RegWre;
    logic               RegDst;
    logic               ExtSel;
    logic               nRD;
    logic               nWR;
    logic [1:0]         PCSrc;
    logic [2:0]         ALUOp;
    logic [STATE_W-1:0] state;
    logic               halted;

    modport master (
        input  op, zero,
        output PCWre, IRWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, RegDst,
               ExtSel, nRD, nWR, PCSrc, ALUOp, state, halted
    );

    modport slave (
        output op, zero,
        input  PCWre, IRWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, RegDst,
               ExtSel, nRD, nWR, PCSrc, ALUOp, state, halted
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control unit: sequences IF/ID/EXE/MEM/WB for the CPU datapath.
// Controls are decoded from the registered state plus the instruction-register opcode.
module multi_cycle_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    multi_cycle_ctrl_if.master  ctrl
);
    localparam int unsigned ENC_W = 4;
    localparam int unsigned OP_W  = 6;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
    localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
    localparam logic [OP_W-1:0] OP_OR    = 6'b010010;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b010011;
    localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OP_W-1:0] OP_SW    = 6'b100110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100111;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b110000;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b110001;
    localparam logic [OP_W-1:0] OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [ENC_W-1:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_is_alu, w_is_br, w_is_ls, w_is_lw, w_is_sw;
    logic w_is_j, w_is_halt, w_is_nop, w_taken, w_dec;

    logic       w_pcwre, w_irwre, w_alusrca, w_alusrcb, w_dbdatasrc;
    logic       w_regwre, w_regdst, w_extsel, w_nrd, w_nwr, w_halted;
    logic [1:0] w_pcsrc;
    logic [2:0] w_aluop;

    // Opcode classification
    always_comb begin
        w_is_alu  = 1'b0;
        w_is_br   = 1'b0;
        w_is_ls   = 1'b0;
        w_is_lw   = 1'b0;
        w_is_sw   = 1'b0;
        w_is_j    = 1'b0;
        w_is_halt = 1'b0;
        w_is_nop  = 1'b0;
        w_taken   = 1'b0;
        case (ctrl.op)
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND,
            OP_OR, OP_ORI, OP_SLL: w_is_alu = 1'b1;
            OP_SW: begin
                w_is_ls = 1'b1;
                w_is_sw = 1'b1;
            end
            OP_LW: begin
                w_is_ls = 1'b1;
                w_is_lw = 1'b1;
            end
            OP_BEQ: begin
                w_is_br = 1'b1;
                w_taken = ctrl.zero;
            end
            OP_BNE: begin
                w_is_br = 1'b1;
                w_taken = ~ctrl.zero;
            end
            OP_J:    w_is_j    = 1'b1;
            OP_HALT: w_is_halt = 1'b1;
            default: w_is_nop  = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) r_state <= S_IF;
        else      r_state <= w_next;
    end

    // Next state and controls; write enables and strobes are forced inactive while RST=0
    always_comb begin
        w_next      = r_state;
        w_pcwre     = 1'b0;
        w_irwre     = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = 1'b0;
        w_dbdatasrc = 1'b0;
        w_regwre    = 1'b0;
        w_regdst    = 1'b0;
        w_extsel    = 1'b0;
        w_nrd       = 1'b1;
        w_nwr       = 1'b1;
        w_halted    = 1'b0;
        w_pcsrc     = 2'b00;
        w_aluop     = 3'b000;
        w_dec       = (r_state != S_IF) && (r_state != S_HALT);

        case (r_state)
            S_IF: begin
                w_irwre = 1'b1;
                w_next  = S_ID;
            end
            S_ID: begin
                if (w_is_j || w_is_nop) begin
                    w_pcwre = 1'b1;
                    w_pcsrc = w_is_j ? 2'b10 : 2'b00;
                    w_next  = S_IF;
                end else if (w_is_halt) begin
                    w_next = S_HALT;
                end else if (w_is_br) begin
                    w_next = S_EXE_BR;
                end else if (w_is_ls) begin
                    w_next = S_EXE_LS;
                end else begin
                    w_next = S_EXE_AL;
                end
            end
            S_EXE_AL: w_next = S_WB_AL;
            S_WB_AL: begin
                w_pcwre  = 1'b1;
                w_regwre = 1'b1;
                w_next   = S_IF;
            end
            S_EXE_BR: begin
                w_pcwre = 1'b1;
                w_pcsrc = w_taken ? 2'b01 : 2'b00;
                w_next  = S_IF;
            end
            S_EXE_LS: w_next = S_MEM;
            S_MEM: begin
                w_nrd = ~w_is_lw;
                w_nwr = ~w_is_sw;
                if (w_is_lw) begin
                    w_next = S_WB_LD;
                end else begin
                    w_pcwre = 1'b1;
                    w_next  = S_IF;
                end
            end
            S_WB_LD: begin
                w_pcwre     = 1'b1;
                w_regwre    = 1'b1;
                w_dbdatasrc = 1'b1;
                w_next      = S_IF;
            end
            S_HALT: begin
                w_halted = 1'b1;
                w_next   = S_HALT;
            end
            default: w_next = S_IF;
        endcase

        // Datapath steering held for the whole instruction once decoded
        if (w_dec) begin
            w_alusrca = (ctrl.op == OP_SLL);
            w_alusrcb = w_is_ls || (ctrl.op inside {OP_ADDIU, OP_ORI, OP_SLL});
            w_extsel  = w_is_ls || w_is_br || (ctrl.op == OP_ADDIU);
            w_regdst  = ctrl.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL};
            case (ctrl.op)
                OP_SUB, OP_BEQ, OP_BNE: w_aluop = 3'b001;
                OP_SLL:                 w_aluop = 3'b010;
                OP_OR, OP_ORI:          w_aluop = 3'b011;
                OP_AND:                 w_aluop = 3'b100;
                default:                w_aluop = 3'b000;
            endcase
        end

        if (!RST) begin
            w_pcwre     = 1'b0;
            w_irwre     = 1'b0;
            w_alusrca   = 1'b0;
            w_alusrcb   = 1'b0;
            w_dbdatasrc = 1'b0;
            w_regwre    = 1'b0;
            w_regdst    = 1'b0;
            w_extsel    = 1'b0;
            w_nrd       = 1'b1;
            w_nwr       = 1'b1;
            w_halted    = 1'b0;
            w_pcsrc     = 2'b00;
            w_aluop     = 3'b000;
        end
    end

    assign ctrl.PCWre     = w_pcwre;
    assign ctrl.IRWre     = w_irwre;
    assign ctrl.ALUSrcA   = w_alusrca;
    assign ctrl.ALUSrcB   = w_alusrcb;
    assign ctrl.DBDataSrc = w_dbdatasrc;
    assign ctrl.RegWre    = w_regwre;
    assign ctrl.RegDst    = w_regdst;
    assign ctrl.ExtSel    = w_extsel;
    assign ctrl.nRD       = w_nrd;
    assign ctrl.nWR       = w_nwr;
    assign ctrl.PCSrc     = w_pcsrc;
    assign ctrl.ALUOp     = w_aluop;
    assign ctrl.state     = STATE_W'(r_state);
    assign ctrl.halted    = w_halted;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: an instruction-level model queues the
// expected per-cycle control vector; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;
    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    multi_cycle_ctrl_if #(.STATE_W(4)) bus ();

    multi_cycle_ctrl #(.STATE_W(4)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .ctrl (bus)
    );

    // {state, PCWre, IRWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, RegDst, ExtSel, nRD, nWR, PCSrc, ALUOp, halted}
    logic [19:0] exp_q[$];
    int          n_vec  = 0;
    int          n_err  = 0;
    bit          mon_on = 1'b0;

    logic [5:0] op_tab[13] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
                               6'b010010, 6'b010011, 6'b011000, 6'b100110,
                               6'b100111, 6'b110000, 6'b110001, 6'b111000,
                               6'b101010};

    function automatic logic [19:0] actual_vec();
        return {bus.state, bus.PCWre, bus.IRWre, bus.ALUSrcA, bus.ALUSrcB,
                bus.DBDataSrc, bus.RegWre, bus.RegDst, bus.ExtSel, bus.nRD,
                bus.nWR, bus.PCSrc, bus.ALUOp, bus.halted};
    endfunction

    function automatic logic [19:0] reset_vec(input logic [3:0] st);
        return {st, 8'b0, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0};
    endfunction

    function automatic logic [2:0] alu_fn(input logic [5:0] op);
        if (op == 6'b000001 || op == 6'b110000 || op == 6'b110001) return 3'b001;
        if (op == 6'b011000) return 3'b010;
        if (op == 6'b010010 || op == 6'b010011) return 3'b011;
        if (op == 6'b010000) return 3'b100;
        return 3'b000;
    endfunction

    // Queue the expected vectors of one instruction (first ncyc cycles, 0 = all) and return that count
    task automatic push_instr(input logic [5:0] op, input logic z, input int ncyc, output int n);
        logic [3:0] st[$];
        bit is_alu, is_br, is_lw, is_sw, is_j, is_halt, is_rtype, imm, sext, taken;
        is_rtype = (op inside {6'b000000, 6'b000001, 6'b010000, 6'b010010, 6'b011000});
        is_alu   = is_rtype || (op inside {6'b000010, 6'b010011});
        is_br    = (op == 6'b110000) || (op == 6'b110001);
        is_lw    = (op == 6'b100111);
        is_sw    = (op == 6'b100110);
        is_j     = (op == 6'b111000);
        is_halt  = (op == 6'b111111);
        imm      = is_lw || is_sw || (op inside {6'b000010, 6'b010011, 6'b011000});
        sext     = is_lw || is_sw || is_br || (op == 6'b000010);
        taken    = (op == 6'b110000) ? z : ((op == 6'b110001) ? !z : 1'b0);
        if (is_alu)       st = '{4'h0, 4'h1, 4'h6, 4'h7};
        else if (is_br)   st = '{4'h0, 4'h1, 4'h5};
        else if (is_sw)   st = '{4'h0, 4'h1, 4'h2, 4'h3};
        else if (is_lw)   st = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
        else if (is_halt) begin
            st = '{4'h0, 4'h1};
            for (int i = 0; i < 10; i++) st.push_back(4'h8);
        end
        else              st = '{4'h0, 4'h1};
        n = (ncyc == 0) ? st.size() : ncyc;
        for (int k = 0; k < n; k++) begin
            bit last, dec;
            logic [1:0] pcsrc;
            last  = (k == st.size() - 1);
            dec   = (k >= 1) && (st[k] != 4'h8);
            pcsrc = (last && is_j) ? 2'b10 : ((last && is_br && taken) ? 2'b01 : 2'b00);
            exp_q.push_back({st[k],
                             last && !is_halt,
                             k == 0,
                             dec && (op == 6'b011000),
                             dec && imm,
                             last && is_lw,
                             last && (is_alu || is_lw),
                             dec && is_rtype,
                             dec && sext,
                             !(is_lw && k == 3),
                             !(is_sw && k == 3),
                             pcsrc,
                             dec ? alu_fn(op) : 3'b000,
                             st[k] == 4'h8});
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int ncyc);
        int n;
        bus.op   = op;
        bus.zero = z;
        push_instr(op, z, ncyc, n);
        repeat (n) tick();
    endtask

    always @(negedge CLK) begin
        if (mon_on) begin
            logic [19:0] e, a;
            n_vec++;
            a = actual_vec();
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL underflow: got %h, required a queued expectation", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display("FAIL ctrl_vec op=%b zero=%b rst=%b: got %h required %h",
                             bus.op, bus.zero, RST, a, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rop;
        RST      = 1'b0;
        bus.op   = 6'b100110;
        bus.zero = 1'b0;
        tick();
        exp_q.push_back(reset_vec(4'h0));
        mon_on = 1'b1;
        tick();
        RST = 1'b1;
        run_instr(6'b100110, 1'b0, 0);
        run_instr(6'b000000, 1'b0, 0);
        run_instr(6'b100111, 1'b0, 0);
        run_instr(6'b110000, 1'b1, 0);
        run_instr(6'b110000, 1'b0, 0);
        run_instr(6'b110001, 1'b0, 0);
        run_instr(6'b110001, 1'b1, 0);
        run_instr(6'b111000, 1'b0, 0);
        run_instr(6'b101010, 1'b0, 0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) rop = 6'($urandom_range(0, 62));
            else                           rop = op_tab[$urandom_range(0, 12)];
            run_instr(rop, 1'($urandom_range(0, 1)), 0);
        end

        run_instr(6'b111111, 1'b0, 0);
        RST = 1'b0;
        exp_q.push_back(reset_vec(4'h8));
        tick();
        RST = 1'b1;

        run_instr(6'b000000, 1'b0, 3);
        RST = 1'b0;
        exp_q.push_back(reset_vec(4'h7));
        tick();
        RST = 1'b1;

        for (int i = 0; i < 40; i++)
            run_instr(op_tab[$urandom_range(0, 12)], 1'($urandom_range(0, 1)), 0);

        mon_on = 1'b0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle control unit that sequences the existing CPU datapath (PC, instruction memory, regfile, extend unit, ALU, RAM, write-back mux) through IF/ID/EXE/MEM/WB states instead of issuing all controls in one cycle.
- Drives the same control signal set, plus IRWre for a new instruction register and a halted flag.
- Sits beside the datapath. It reads op from the instruction register and zero from the ALU.

Parameters:
- STATE_W, 4, width of the state register and of the state output.

Ports:
- CLK  in  1  clock; all state changes occur on the rising edge.
- RST  in  1  synchronous active-low reset.
- op  in  6  opcode from instruction register bits [31:26].
- zero  in  1  ALU zero flag.
- PCWre  out  1  PC write enable.
- IRWre  out  1  instruction register write enable.
- ALUSrcA  out  1  1 = shamt, 0 = rs data.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt data.
- DBDataSrc  out  1  1 = RAM data, 0 = ALU result.
- RegWre  out  1  regfile write enable.
- RegDst  out  1  1 = rd, 0 = rt.
- ExtSel  out  1  1 = sign extend, 0 = zero extend.
- nRD  out  1  RAM read strobe, active low.
- nWR  out  1  RAM write strobe, active low.
- PCSrc  out  2  00 = PC+4, 01 = branch, 10 = jump.
- ALUOp  out  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and.
- state  out  STATE_W  current state, for debug.
- halted  out  1  high while in HALT.

Behaviour:
- Clock and reset: one clock, CLK. Reset is RST, synchronous and active-low. RST=0 sampled on an edge forces state=IF.
- Outputs while RST=0: PCWre=0, IRWre=0, RegWre=0, nRD=1, nWR=1, halted=0, PCSrc=00, ALUOp=000, all other 1-bit outputs 0. Write-enables are gated by RST, so a mid-instruction reset causes no regfile, RAM or PC write on that edge.
- Opcodes:
  - add 000000, sub 000001, addiu 000010, and 010000, or 010010, ori 010011, sll 011000
  - sw 100110, lw 100111, beq 110000, bne 110001, j 111000, halt 111111
  - any other opcode is a NOP.
- State encodings: IF 0000, ID 0001, EXE_AL 0110, EXE_BR 0101, EXE_LS 0010, MEM 0011, WB_AL 0111, WB_LD 0100, HALT 1000.
- Transitions:
  - IF -> ID.
  - ID -> IF for j and NOP.
  - ID -> HALT for halt.
  - ID -> EXE_BR for beq/bne.
  - ID -> EXE_LS for lw/sw.
  - ID -> EXE_AL otherwise.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> WB_LD for lw; MEM -> IF for sw.
  - WB_LD -> IF.
  - HALT -> HALT until reset.
- Outputs are a function of the registered state and the current op. op is stable from ID onward, because IRWre is high only in IF.
- IRWre=1 only in IF.
- PCWre=1 exactly once per instruction, in the final cycle of the instruction:
  - ID for j/NOP, with PCSrc=10 for j and 00 for NOP
  - EXE_BR, with PCSrc=01 if (beq & zero) or (bne & !zero), else 00
  - MEM for sw
  - WB_AL
  - WB_LD
- PCWre=0 in HALT.
- Control decode, driven from ID through WB for the current instruction:
  - ALUSrcA=1 only for sll.
  - ALUSrcB=1 for addiu, ori, lw, sw, sll.
  - ExtSel=1 for addiu, lw, sw, beq, bne; ExtSel=0 for ori.
  - RegDst=1 for R-type (add, sub, and, or, sll); 0 for I-type.
  - ALUOp=001 for beq/bne/sub.
- Write-backs and memory strobes:
  - RegWre=1 only in WB_AL and WB_LD.
  - DBDataSrc=1 only in WB_LD.
  - nRD=0 only in MEM for lw.
  - nWR=0 only in MEM for sw.
- Cycles per instruction: j/NOP 2, beq/bne 3, sw 4, R/I ALU 4, lw 5.

Test Plan:
- Reset: hold RST=0 for 2 edges with op=100110 -> state=0000, PCWre=0, nWR=1, RegWre=0. Release -> state sequence 0000,0001,0010,0011; nWR=0 only in 0011.
- add (op=000000) -> states IF,ID,EXE_AL,WB_AL. In WB_AL: RegWre=1, RegDst=1, ALUOp=000, PCWre=1, PCSrc=00. Back to IF after 4 cycles.
- lw (op=100111) -> 5 cycles. nRD=0 in MEM. WB_LD: DBDataSrc=1, RegWre=1, RegDst=0, ALUSrcB=1, ExtSel=1.
- beq with zero=1 -> EXE_BR: PCWre=1, PCSrc=01. Repeat with zero=0 -> PCSrc=00. bne with zero=0 -> PCSrc=01.
- j (op=111000) -> ID: PCWre=1, PCSrc=10, next state IF. Unknown op=101010 -> ID: PCWre=1, PCSrc=00, RegWre never asserted.
- halt (op=111111) -> state=1000, halted=1, PCWre=0 for 10 cycles. RST=0 for one edge -> IF, halted=0. Assert RST=0 while in WB_AL -> RegWre=0 that cycle, state=IF next.
